bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles per owner (legal 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port req, input, 8 bits: req[i] high = requester i wants to drive the 8-bit internal bus; held high for the whole transfer.
REQ-005 The module SHALL have port gnt, output, 8 bits: registered one-hot grant; all-zero when no owner.
REQ-006 The module SHALL have port sel, output, 3 bits: registered index of the current or last owner; drives the select of the 8-input bus multiplexer.
REQ-007 The module SHALL have port bus_valid, output, 1 bit: registered; high exactly when gnt is non-zero.
REQ-008 The module SHALL have port preempt, output, 1 bit: registered one-cycle pulse marking a forced release on MAX_HOLD expiry.

Function
REQ-009 The module SHALL implement three states: IDLE, GRANT and RELEASE.
REQ-010 The module SHALL keep an internal 3-bit round-robin pointer ptr and an 8-bit hold counter hold_cnt.
REQ-011 In IDLE with req != 0, the module SHALL pick the first set bit of req scanning ptr, ptr+1, ... modulo 8 (wrap 7->0), then next cycle: state GRANT, gnt one-hot at winner, sel = winner index, bus_valid=1, hold_cnt=1.
REQ-012 In IDLE with req == 0, the module SHALL stay in IDLE with gnt=0 and bus_valid=0, and sel SHALL hold its previous value.
REQ-013 Grant latency SHALL be exactly 1 cycle: req sampled in IDLE at edge N gives gnt at edge N+1.
REQ-014 In GRANT, if req[owner]=1 and hold_cnt<MAX_HOLD, the module SHALL stay in GRANT and increment hold_cnt; gnt and sel SHALL stay unchanged.
REQ-015 In GRANT, if req[owner]=0, the module SHALL go to RELEASE next cycle with preempt=0.
REQ-016 In GRANT, if req[owner]=1 and hold_cnt==MAX_HOLD, the module SHALL go to RELEASE next cycle with preempt=1 for that one cycle.
REQ-017 If req[owner] drops in the same cycle hold_cnt reaches MAX_HOLD, the module SHALL treat it as a normal release (preempt=0).
REQ-018 Requests from non-owners during GRANT SHALL have no effect on gnt, sel or hold_cnt.
REQ-019 In RELEASE, the module SHALL drive gnt=0 and bus_valid=0 (one dead bus cycle), keep sel at the old owner, set ptr = (owner+1) mod 8, and go to IDLE next cycle.
REQ-020 preempt SHALL be 0 in every cycle other than the RELEASE cycle after a forced release.
REQ-021 A requester that drops req and reasserts it SHALL be arbitrated again only through IDLE, at the priority its position relative to ptr gives.
REQ-022 Any requester holding req continuously SHALL be granted within at most 7 intervening grants to other requesters.
REQ-023 With MAX_HOLD=1, each grant SHALL last exactly 1 cycle followed by RELEASE, with preempt=1 if req is still high.

Reset
REQ-024 When rst=1 at a clock edge, the module SHALL set state=IDLE, gnt=8'h00, sel=3'd0, bus_valid=0, preempt=0, ptr=3'd0 and hold_cnt=0, overriding all other inputs.
REQ-025 rst asserted mid-GRANT SHALL drop gnt at the next edge with no RELEASE cycle and no preempt pulse.
REQ-026 After rst deasserts, arbitration SHALL resume from IDLE with ptr=0.

Verification
REQ-027 Test: after reset, req=8'h24 at edge N -> at N+1 gnt=8'h04, sel=2, bus_valid=1; drop req[2] -> RELEASE (gnt=0) then IDLE; next grant gnt=8'h20, sel=5.
REQ-028 Test: MAX_HOLD=8, req=8'h01 held constantly -> gnt=8'h01 for exactly 8 cycles, then 1 RELEASE cycle with preempt=1, then IDLE, then re-grant of requester 0.
REQ-029 Test: req=8'hFF held constantly -> grant order sel=0,1,2,...,7,0 (wrap), each grant separated by RELEASE and IDLE cycles.
REQ-030 Test: ptr=7 (after requester 6 served) with req=8'h41 -> requester 0 wins (wrap), not requester 6.
REQ-031 Test: req[owner] drops on the cycle hold_cnt==MAX_HOLD -> RELEASE with preempt=0.
REQ-032 Test: rst=1 during GRANT of requester 3 -> next edge gnt=0, sel=0, bus_valid=0, preempt=0; with req=8'h08 after reset, granted again 1 cycle after rst deasserts.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: 8-requester round-robin bus arbiter with a bounded hold time.
// Revision: 1.0 - initial release
`default_nettype none

module bus_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       bus_valid,
   output logic       preempt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] hold_cnt;
   logic [2:0] winner;
   logic [2:0] scan_idx;

   // Scan downwards so the candidate closest to ptr is the last one written.
   always_comb begin
      winner   = ptr;
      scan_idx = ptr;
      for (int k = 7; k >= 0; k--) begin
         scan_idx = ptr + 3'(k);
         if (req[scan_idx]) begin
            winner = scan_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= 8'h00;
         sel       <= 3'd0;
         bus_valid <= 1'b0;
         preempt   <= 1'b0;
         ptr       <= 3'd0;
         hold_cnt  <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               preempt <= 1'b0;
               if (req != 8'h00) begin
                  state     <= GRANT;
                  gnt       <= 8'd1 << winner;
                  sel       <= winner;
                  bus_valid <= 1'b1;
                  hold_cnt  <= 8'd1;
               end else begin
                  gnt       <= 8'h00;
                  bus_valid <= 1'b0;
               end
            end
            GRANT: begin
               if (req[sel] && (hold_cnt < HOLD_LIMIT)) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end else begin
                  // A dropped request wins over expiry, so preempt marks only forced releases.
                  state     <= RELEASE;
                  gnt       <= 8'h00;
                  bus_valid <= 1'b0;
                  preempt   <= req[sel];
                  ptr       <= sel + 3'd1;
                  hold_cnt  <= 8'd0;
               end
            end
            RELEASE: begin
               state     <= IDLE;
               gnt       <= 8'h00;
               bus_valid <= 1'b0;
               preempt   <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               gnt       <= 8'h00;
               bus_valid <= 1'b0;
               preempt   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (MAX_HOLD = 8).
// Revision: 1.0 - initial release
`default_nettype none

module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       bus_valid;
   logic       preempt;

   int checks   = 0;
   int failures = 0;

   bus_arbiter #(.MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .sel       (sel),
      .bus_valid (bus_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n edges; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step(input int n);
      for (int s = 0; s < n; s++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] es,
                            input logic ev, input logic ep);
      check_eq({tag, ".gnt"}, 32'(gnt), 32'(eg));
      check_eq({tag, ".sel"}, 32'(sel), 32'(es));
      check_eq({tag, ".bus_valid"}, 32'(bus_valid), 32'(ev));
      check_eq({tag, ".preempt"}, 32'(preempt), 32'(ep));
   endtask

   initial begin
      rst = 1'b1;
      req = 8'h00;
      step(2);
      check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

      // Basic grant, release, and next-in-line grant.
      rst = 1'b0;
      req = 8'h24;
      step(1);
      check_out("g2", 8'h04, 3'd2, 1'b1, 1'b0);
      req = 8'h20;
      step(1);
      check_out("rel2", 8'h00, 3'd2, 1'b0, 1'b0);
      step(1);
      check_out("idle2", 8'h00, 3'd2, 1'b0, 1'b0);
      step(1);
      check_out("g5", 8'h20, 3'd5, 1'b1, 1'b0);
      req = 8'h00;
      step(2);
      check_out("idle5", 8'h00, 3'd5, 1'b0, 1'b0);
      step(1);
      check_out("idle_hold_sel", 8'h00, 3'd5, 1'b0, 1'b0);

      // Hold expiry with ptr=6: requester 0 wins via wrap, held 8 cycles, forced release.
      req = 8'h01;
      step(1);
      check_out("g0_c1", 8'h01, 3'd0, 1'b1, 1'b0);
      for (int c = 2; c <= 8; c++) begin
         step(1);
         check_out($sformatf("g0_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
      end
      step(1);
      check_out("forced_rel0", 8'h00, 3'd0, 1'b0, 1'b1);
      step(1);
      check_out("idle_after_forced", 8'h00, 3'd0, 1'b0, 1'b0);
      step(1);
      check_out("regrant0", 8'h01, 3'd0, 1'b1, 1'b0);
      req = 8'h00;
      step(1);
      check_out("rel0_normal", 8'h00, 3'd0, 1'b0, 1'b0);
      step(1);

      // Request drops exactly when hold_cnt reaches the limit: normal release.
      req = 8'h02;
      step(1);
      check_out("g1", 8'h02, 3'd1, 1'b1, 1'b0);
      step(7);
      check_out("g1_c8", 8'h02, 3'd1, 1'b1, 1'b0);
      req = 8'h00;
      step(1);
      check_out("rel1_at_limit", 8'h00, 3'd1, 1'b0, 1'b0);
      step(1);

      // Full contention from ptr=0: order 0..7 then wrap to 0, with non-owners ignored.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      req = 8'hFF;
      for (int g = 0; g <= 8; g++) begin
         step(1);
         check_out($sformatf("rr%0d", g), 8'd1 << (g % 8), 3'(g % 8), 1'b1, 1'b0);
         step(7);
         check_eq($sformatf("rr%0d_held", g), 32'(gnt), 32'(8'd1 << (g % 8)));
         step(1);
         check_out($sformatf("rr%0d_rel", g), 8'h00, 3'(g % 8), 1'b0, 1'b1);
         step(1);
         check_out($sformatf("rr%0d_idle", g), 8'h00, 3'(g % 8), 1'b0, 1'b0);
      end

      // After requester 6 is served, ptr=7 and requester 0 beats requester 6.
      rst = 1'b1;
      req = 8'h00;
      step(1);
      rst = 1'b0;
      req = 8'h40;
      step(1);
      check_out("g6", 8'h40, 3'd6, 1'b1, 1'b0);
      req = 8'h00;
      step(1);
      req = 8'h41;
      step(1);
      check_out("idle6", 8'h00, 3'd6, 1'b0, 1'b0);
      step(1);
      check_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);

      // Reset mid-grant drops the bus immediately, then arbitration restarts.
      rst = 1'b1;
      req = 8'h00;
      step(1);
      rst = 1'b0;
      req = 8'h08;
      step(1);
      check_out("g3", 8'h08, 3'd3, 1'b1, 1'b0);
      step(1);
      rst = 1'b1;
      step(1);
      check_out("rst_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step(1);
      check_out("g3_after_rst", 8'h08, 3'd3, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
